// File: rtl/usb_ep_pkg.sv
// Shared types and constants for the USB endpoint echo client.
package usb_ep_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    POP_COMMIT,
    FILL,
    FILL_ABORT,
    FILL_COMMIT
  } EchoState_t;

  // Consecutive full_i cycles tolerated mid-fill before the OUT transaction is abandoned
  localparam int unsigned ECHO_STALL_LIMIT = 255;
  localparam int unsigned ECHO_STALL_W     = $clog2(ECHO_STALL_LIMIT + 1);

endpackage

// File: rtl/usb_ep_echo_client_if.sv
// Endpoint-side handshake bundle between the protocol engine (master) and the echo client (slave).
interface usb_ep_echo_client_if;

  logic       EP_IN_dataAvailable_i;
  logic [7:0] EP_IN_data_i;
  logic       EP_IN_popData_o;
  logic       EP_IN_popTransDone_o;
  logic       EP_IN_popTransSuccess_o;

  logic       EP_OUT_full_i;
  logic       EP_OUT_dataValid_o;
  logic [7:0] EP_OUT_data_o;
  logic       EP_OUT_fillTransDone_o;
  logic       EP_OUT_fillTransSuccess_o;

  modport master (
    output EP_IN_dataAvailable_i, EP_IN_data_i, EP_OUT_full_i,
    input  EP_IN_popData_o, EP_IN_popTransDone_o, EP_IN_popTransSuccess_o,
    input  EP_OUT_dataValid_o, EP_OUT_data_o, EP_OUT_fillTransDone_o, EP_OUT_fillTransSuccess_o
  );

  modport slave (
    input  EP_IN_dataAvailable_i, EP_IN_data_i, EP_OUT_full_i,
    output EP_IN_popData_o, EP_IN_popTransDone_o, EP_IN_popTransSuccess_o,
    output EP_OUT_dataValid_o, EP_OUT_data_o, EP_OUT_fillTransDone_o, EP_OUT_fillTransSuccess_o
  );

endinterface

// File: rtl/usb_ep_echo_buf.sv
// Byte buffer for one echoed transaction: single write port, registered single read port.
module usb_ep_echo_buf #(
  parameter int unsigned MAX_BYTES = 64,
  parameter int unsigned ADDR_W    = $clog2(MAX_BYTES)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [7:0]        i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [7:0]        o_rdata
);

  logic [7:0] r_mem [MAX_BYTES];
  logic [7:0] r_rdata;

  // No reset so the array maps onto block RAM
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/usb_ep_echo_client.sv
// Loopback client: drains one IN transaction into a buffer, then replays it as one OUT transaction.
// Optional USB_EP_ECHO_STATS_EN adds txnCount_o / retryCount_o statistics outputs.
module usb_ep_echo_client
  import usb_ep_pkg::*;
#(
  parameter int unsigned MAX_BYTES = 64
) (
  input  logic                clk12_i,
  input  logic                rst_ni,
  usb_ep_echo_client_if.slave ep,
  output logic                busy_o,
  output logic                overflow_o
`ifdef USB_EP_ECHO_STATS_EN
  ,
  output logic [15:0]         txnCount_o,
  output logic [7:0]          retryCount_o
`endif
);

  localparam int unsigned              ADDR_W        = $clog2(MAX_BYTES);
  localparam int unsigned              PTR_W         = ADDR_W + 1;
  localparam logic [PTR_W-1:0]         MAX_PTR       = PTR_W'(MAX_BYTES);
  localparam logic [ECHO_STALL_W-1:0]  STALL_TC_LOAD = ECHO_STALL_W'(ECHO_STALL_LIMIT - 1);

  EchoState_t              r_state;
  EchoState_t              w_state_nxt;
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [PTR_W-1:0]        r_len;
  logic [PTR_W-1:0]        w_rd_ptr_nxt;
  logic                    r_pop_ok;
  logic                    r_overflow;
  logic                    r_abort_sent;
  logic [ECHO_STALL_W-1:0] r_stall_cnt;
  logic [7:0]              w_rdata;
  logic                    w_pop;
  logic                    w_fill_valid;
  logic                    w_fill_take;
  logic                    w_stalled;

  assign w_pop        = (r_state == POP) && ep.EP_IN_dataAvailable_i && (r_wr_ptr < MAX_PTR);
  assign w_fill_valid = (r_state == FILL) && (r_rd_ptr < r_len);
  assign w_fill_take  = w_fill_valid && !ep.EP_OUT_full_i;
  assign w_stalled    = w_fill_valid && ep.EP_OUT_full_i;

  // Read address runs one step ahead so the registered RAM output always equals buf[rd_ptr]
  always_comb begin
    w_rd_ptr_nxt = r_rd_ptr;
    if ((r_state == FILL_ABORT) || (r_state == FILL_COMMIT)) begin
      w_rd_ptr_nxt = '0;
    end else if (w_fill_take) begin
      w_rd_ptr_nxt = r_rd_ptr + 1'b1;
    end
  end

  usb_ep_echo_buf #(
    .MAX_BYTES (MAX_BYTES),
    .ADDR_W    (ADDR_W)
  ) u_buf (
    .i_clk   (clk12_i),
    .i_we    (w_pop),
    .i_waddr (r_wr_ptr[ADDR_W-1:0]),
    .i_wdata (ep.EP_IN_data_i),
    .i_raddr (w_rd_ptr_nxt[ADDR_W-1:0]),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk12_i) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt                  = r_state;
    ep.EP_IN_popData_o           = w_pop;
    ep.EP_IN_popTransDone_o      = 1'b0;
    ep.EP_IN_popTransSuccess_o   = 1'b0;
    ep.EP_OUT_dataValid_o        = w_fill_valid;
    ep.EP_OUT_data_o             = w_fill_valid ? w_rdata : 8'h00;
    ep.EP_OUT_fillTransDone_o    = 1'b0;
    ep.EP_OUT_fillTransSuccess_o = 1'b0;
    busy_o                       = (r_state != IDLE);
    unique case (r_state)
      IDLE: begin
        if (ep.EP_IN_dataAvailable_i) begin
          w_state_nxt = POP;
        end
      end
      POP: begin
        if (!ep.EP_IN_dataAvailable_i || (r_wr_ptr == MAX_PTR)) begin
          w_state_nxt = POP_COMMIT;
        end
      end
      POP_COMMIT: begin
        ep.EP_IN_popTransDone_o    = 1'b1;
        ep.EP_IN_popTransSuccess_o = r_pop_ok;
        if (!r_pop_ok) begin
          w_state_nxt = IDLE;
        end else if (r_wr_ptr == '0) begin
          w_state_nxt = FILL_COMMIT;
        end else begin
          w_state_nxt = FILL;
        end
      end
      FILL: begin
        if (r_rd_ptr == r_len) begin
          w_state_nxt = FILL_COMMIT;
        end else if (w_stalled && (r_stall_cnt == '0)) begin
          w_state_nxt = FILL_ABORT;
        end
      end
      FILL_ABORT: begin
        ep.EP_OUT_fillTransDone_o = !r_abort_sent;
        if (!ep.EP_OUT_full_i) begin
          w_state_nxt = FILL;
        end
      end
      FILL_COMMIT: begin
        ep.EP_OUT_fillTransDone_o    = 1'b1;
        ep.EP_OUT_fillTransSuccess_o = 1'b1;
        w_state_nxt                  = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk12_i) begin
    if (!rst_ni) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_len        <= '0;
      r_pop_ok     <= 1'b0;
      r_overflow   <= 1'b0;
      r_abort_sent <= 1'b0;
      r_stall_cnt  <= STALL_TC_LOAD;
    end else begin
      r_rd_ptr     <= w_rd_ptr_nxt;
      r_abort_sent <= (r_state == FILL_ABORT);
      if (w_pop) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if ((r_state == POP) && (w_state_nxt == POP_COMMIT)) begin
        r_pop_ok <= !ep.EP_IN_dataAvailable_i;
        if (ep.EP_IN_dataAvailable_i) begin
          r_overflow <= 1'b1;
          r_len      <= '0;
        end
      end
      // A rolled-back transaction leaves nothing to echo, so the write side restarts at 0
      if (r_state == POP_COMMIT) begin
        if (r_pop_ok) begin
          r_len <= r_wr_ptr;
        end else begin
          r_wr_ptr <= '0;
        end
      end
      if (r_state == FILL_COMMIT) begin
        r_wr_ptr <= '0;
      end
      if (!w_stalled) begin
        r_stall_cnt <= STALL_TC_LOAD;
      end else if (r_stall_cnt != '0) begin
        r_stall_cnt <= r_stall_cnt - 1'b1;
      end
    end
  end

  assign overflow_o = r_overflow;

`ifdef USB_EP_ECHO_STATS_EN
  logic [15:0] r_txn_cnt;
  logic [7:0]  r_retry_cnt;

  always_ff @(posedge clk12_i) begin
    if (!rst_ni) begin
      r_txn_cnt   <= '0;
      r_retry_cnt <= '0;
    end else begin
      if (r_state == FILL_COMMIT) begin
        r_txn_cnt <= r_txn_cnt + 16'd1;
      end
      if ((r_state == FILL_ABORT) && !r_abort_sent && (r_retry_cnt != 8'hFF)) begin
        r_retry_cnt <= r_retry_cnt + 8'd1;
      end
    end
  end

  assign txnCount_o   = r_txn_cnt;
  assign retryCount_o = r_retry_cnt;
`endif

endmodule

// File: tb/tb_usb_ep_echo_client.sv
// Scoreboard bench for usb_ep_echo_client: directed IN transactions, OUT flow control, reset abort.
module tb_usb_ep_echo_client;

  localparam logic [1:0] K_POPDONE  = 2'd0;
  localparam logic [1:0] K_DATA     = 2'd1;
  localparam logic [1:0] K_FILLDONE = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] val;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  logic ovf;
`ifdef USB_EP_ECHO_STATS_EN
  logic [15:0] txn_cnt;
  logic [7:0]  retry_cnt;
`endif

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  pop_cnt = 0;

  usb_ep_echo_client_if ep_if();

  usb_ep_echo_client #(.MAX_BYTES(64)) dut (
    .clk12_i    (clk),
    .rst_ni     (rst_n),
    .ep         (ep_if.slave),
    .busy_o     (busy),
    .overflow_o (ovf)
`ifdef USB_EP_ECHO_STATS_EN
    ,
    .txnCount_o   (txn_cnt),
    .retryCount_o (retry_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] kind, input logic [7:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic observe(input logic [1:0] kind, input logic [7:0] val);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event actual=kind%0d/0x%0h expected=none", kind, val);
    end else begin
      e = exp_q.pop_front();
      if ((e.kind !== kind) || (e.val !== val)) begin
        failures++;
        $display("FAIL event_order actual=kind%0d/0x%0h expected=kind%0d/0x%0h", kind, val, e.kind, e.val);
      end
    end
  endtask

  // Monitor: inputs change on the falling edge, everything is sampled 2 units later
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (ep_if.EP_IN_popTransDone_o || ep_if.EP_OUT_fillTransDone_o) begin
          check("done_exclusive", {31'd0, ep_if.EP_IN_popTransDone_o & ep_if.EP_OUT_fillTransDone_o}, 32'd0);
        end
        if (ep_if.EP_IN_popTransDone_o)
          observe(K_POPDONE, {7'd0, ep_if.EP_IN_popTransSuccess_o});
        if (ep_if.EP_OUT_fillTransDone_o)
          observe(K_FILLDONE, {7'd0, ep_if.EP_OUT_fillTransSuccess_o});
        if (ep_if.EP_OUT_dataValid_o && !ep_if.EP_OUT_full_i)
          observe(K_DATA, ep_if.EP_OUT_data_o);
        if (ep_if.EP_IN_popData_o && ep_if.EP_IN_dataAvailable_i)
          pop_cnt++;
      end
    end
  end

  task automatic send_in(input logic [7:0] b[$]);
    int i = 0;
    int guard = 0;
    while (guard < 400) begin
      @(negedge clk);
      if (i >= b.size()) break;
      ep_if.EP_IN_dataAvailable_i = 1'b1;
      ep_if.EP_IN_data_i          = b[i];
      #1;
      if (ep_if.EP_IN_popTransDone_o) break;
      if (ep_if.EP_IN_popData_o) i++;
      guard++;
    end
    ep_if.EP_IN_dataAvailable_i = 1'b0;
    if (guard >= 400) check("send_in_timeout", 32'd1, 32'd0);
  endtask

  task automatic drive_out(input int stall_after, input int stall_len, input bit chk_hold,
                           input logic [7:0] hold_val);
    int  acc = 0;
    int  cyc = 0;
    bit  started = 1'b0;
    bit  stall_done = 1'b0;
    ep_if.EP_OUT_full_i = 1'b0;
    while (cyc < 2000) begin
      @(negedge clk);
      if (!stall_done && (stall_after >= 0) && (acc == stall_after)) begin
        stall_done = 1'b1;
        for (int k = 0; k < stall_len; k++) begin
          ep_if.EP_OUT_full_i = 1'b1;
          #1;
          if (chk_hold) begin
            check("stall_hold_data", {24'd0, ep_if.EP_OUT_data_o}, {24'd0, hold_val});
            check("stall_hold_valid", {31'd0, ep_if.EP_OUT_dataValid_o}, 32'd1);
          end
          @(negedge clk);
        end
        ep_if.EP_OUT_full_i = 1'b0;
      end
      #1;
      if (busy) started = 1'b1;
      else if (started) break;
      if (ep_if.EP_OUT_dataValid_o && !ep_if.EP_OUT_full_i) acc++;
      cyc++;
    end
    if (cyc >= 2000) check("drive_out_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((busy || (exp_q.size() != 0)) && (n < 1000)) begin
      @(negedge clk);
      #3;
      n++;
    end
    check({name, "_queue_empty"}, exp_q.size(), 32'd0);
    check({name, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  function automatic logic [15:0] all_outputs();
    return {ep_if.EP_IN_popData_o, ep_if.EP_IN_popTransDone_o, ep_if.EP_IN_popTransSuccess_o,
            ep_if.EP_OUT_dataValid_o, ep_if.EP_OUT_data_o, ep_if.EP_OUT_fillTransDone_o,
            ep_if.EP_OUT_fillTransSuccess_o, busy, ovf};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t1[$];
    logic [7:0] t3[$];
    logic [7:0] t4[$];
    logic [7:0] t6[$];
    logic [7:0] t6b[$];
    int acc;
    int guard;

    ep_if.EP_IN_dataAvailable_i = 1'b0;
    ep_if.EP_IN_data_i          = 8'h00;
    ep_if.EP_OUT_full_i         = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", {16'd0, all_outputs()}, 32'd0);
    rst_n = 1'b1;

    // 1: four-byte echo
    t1 = '{8'h11, 8'h22, 8'h33, 8'h44};
    push(K_POPDONE, 8'h01);
    foreach (t1[i]) push(K_DATA, t1[i]);
    push(K_FILLDONE, 8'h01);
    pop_cnt = 0;
    send_in(t1);
    drive_out(-1, 0, 1'b0, 8'h00);
    wait_drain("t1");
    check("t1_pops", pop_cnt, 32'd4);

    // 2: zero-length transaction, 1-cycle availability pulse
    push(K_POPDONE, 8'h01);
    push(K_FILLDONE, 8'h01);
    pop_cnt = 0;
    @(negedge clk);
    ep_if.EP_IN_dataAvailable_i = 1'b1;
    @(negedge clk);
    ep_if.EP_IN_dataAvailable_i = 1'b0;
    wait_drain("t2");
    check("t2_pops", pop_cnt, 32'd0);

    // 3: 65 bytes offered into a 64-byte buffer
    for (int i = 0; i < 65; i++) t3.push_back(8'(i + 8'h40));
    push(K_POPDONE, 8'h00);
    pop_cnt = 0;
    send_in(t3);
    wait_drain("t3");
    check("t3_pops", pop_cnt, 32'd64);
    check("t3_overflow", {31'd0, ovf}, 32'd1);

    // 4: short stall after two bytes, data must hold 0x03
    for (int i = 1; i <= 8; i++) t4.push_back(8'(i));
    push(K_POPDONE, 8'h01);
    foreach (t4[i]) push(K_DATA, t4[i]);
    push(K_FILLDONE, 8'h01);
    send_in(t4);
    drive_out(2, 3, 1'b1, 8'h03);
    wait_drain("t4");
    check("t4_overflow_sticky", {31'd0, ovf}, 32'd1);

    // 5: from a fresh reset, 300-cycle stall forces one abort and a full retransmission
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t5_overflow_cleared", {31'd0, ovf}, 32'd0);
    push(K_POPDONE, 8'h01);
    push(K_DATA, 8'h01);
    push(K_DATA, 8'h02);
    push(K_FILLDONE, 8'h00);
    foreach (t4[i]) push(K_DATA, t4[i]);
    push(K_FILLDONE, 8'h01);
    send_in(t4);
    drive_out(2, 300, 1'b0, 8'h00);
    wait_drain("t5");
`ifdef USB_EP_ECHO_STATS_EN
    check("t5_retry_count", {24'd0, retry_cnt}, 32'd1);
    check("t5_txn_count", {16'd0, txn_cnt}, 32'd1);
`endif

    // 6: reset during fill at byte 3, then a clean 2-byte echo
    t6 = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    push(K_POPDONE, 8'h01);
    push(K_DATA, 8'hA0);
    push(K_DATA, 8'hA1);
    push(K_DATA, 8'hA2);
    send_in(t6);
    acc = 0;
    guard = 0;
    while ((acc < 3) && (guard < 200)) begin
      @(negedge clk);
      #1;
      if (ep_if.EP_OUT_dataValid_o) acc++;
      guard++;
    end
    check("t6_reached_byte3", acc, 32'd3);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("t6_outputs_after_reset", {16'd0, all_outputs()}, 32'd0);
    check("t6_busy_after_reset", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    #3;
    check("t6_queue_after_reset", exp_q.size(), 32'd0);
    t6b = '{8'h5A, 8'hC3};
    push(K_POPDONE, 8'h01);
    push(K_DATA, 8'h5A);
    push(K_DATA, 8'hC3);
    push(K_FILLDONE, 8'h01);
    send_in(t6b);
    drive_out(-1, 0, 1'b0, 8'h00);
    wait_drain("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
